encoder_8to3: RTL and testbench

ENCODER_8TO3 -- requirements
Module: encoder_8to3

---
 rtl/encoder_8to3_pkg.sv | 11 +
 rtl/encoder_8to3_if.sv | 12 +
 rtl/encoder_8to3_core.sv | 35 +++
 rtl/encoder_8to3.sv | 51 +++++
 tb/tb_encoder_8to3.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/encoder_8to3_pkg.sv
// rtl/encoder_8to3_pkg.sv - shared widths and result bundle for the 8-to-3 priority encoder
package encoder_8to3_pkg;
   localparam int IN_W   = 8;
   localparam int CODE_W = 3;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic              any;
      logic              multi;
   } enc_result_t;
endpackage

// File: rtl/encoder_8to3_if.sv
// rtl/encoder_8to3_if.sv - request vector and encoded result grouped for the driving side and the encoder side
interface encoder_8to3_if;
   import encoder_8to3_pkg::*;

   logic [IN_W-1:0]   req;
   logic [CODE_W-1:0] code;
   logic              valid;
   logic              err;

   modport master (output req, input code, input valid, input err);
   modport slave  (input req, output code, output valid, output err);
endinterface

// File: rtl/encoder_8to3_core.sv
// rtl/encoder_8to3_core.sv - combinational priority encode, any-request and multi-request detection
module encoder_8to3_core
   import encoder_8to3_pkg::*;
(
   input  logic              A7,
   input  logic              A6,
   input  logic              A5,
   input  logic              A4,
   input  logic              A3,
   input  logic              A2,
   input  logic              A1,
   input  logic              A0,
   output logic [CODE_W-1:0] code,
   output logic              any,
   output logic              multi
);
   logic [IN_W-1:0] w_req;

   assign w_req = {A7, A6, A5, A4, A3, A2, A1, A0};

   // Ascending scan: the last hit wins, which gives the highest index priority.
   always_comb begin
      code = '0;
      for (int k = 0; k < IN_W; k++) begin
         if (w_req[k]) begin
            code = CODE_W'(k);
         end
      end
   end

   assign any = |w_req;

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi = |(w_req & (w_req - IN_W'(1)));
endmodule

// File: rtl/encoder_8to3.sv
// rtl/encoder_8to3.sv - 8-to-3 priority encoder with registered code, valid and error outputs
module encoder_8to3
   import encoder_8to3_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic A7,
   input  logic A6,
   input  logic A5,
   input  logic A4,
   input  logic A3,
   input  logic A2,
   input  logic A1,
   input  logic A0,
   output logic B,
   output logic C,
   output logic D,
   output logic V,
   output logic E
);
   enc_result_t w_next;
   enc_result_t r_out;

   encoder_8to3_core u_core (
      .A7    (A7),
      .A6    (A6),
      .A5    (A5),
      .A4    (A4),
      .A3    (A3),
      .A2    (A2),
      .A1    (A1),
      .A0    (A0),
      .code  (w_next.code),
      .any   (w_next.any),
      .multi (w_next.multi)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_next;
      end
   end

   assign B = r_out.code[2];
   assign C = r_out.code[1];
   assign D = r_out.code[0];
   assign V = r_out.any;
   assign E = r_out.multi;
endmodule

// File: tb/tb_encoder_8to3.sv
// tb/tb_encoder_8to3.sv - directed self-checking bench for encoder_8to3
module tb_encoder_8to3;
   logic clk;
   logic rst;
   logic w_b, w_c, w_d, w_v, w_e;
   int   checks;
   int   passed;

   encoder_8to3_if bus ();

   assign bus.code  = {w_b, w_c, w_d};
   assign bus.valid = w_v;
   assign bus.err   = w_e;

   encoder_8to3 dut (
      .clk (clk),
      .rst (rst),
      .A7  (bus.req[7]),
      .A6  (bus.req[6]),
      .A5  (bus.req[5]),
      .A4  (bus.req[4]),
      .A3  (bus.req[3]),
      .A2  (bus.req[2]),
      .A1  (bus.req[1]),
      .A0  (bus.req[0]),
      .B   (w_b),
      .C   (w_c),
      .D   (w_d),
      .V   (w_v),
      .E   (w_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, then sample 1 unit after the next rising edge.
   task automatic drive_and_step(input logic [7:0] vec, input logic rst_val);
      @(negedge clk);
      bus.req = vec;
      rst     = rst_val;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      for (int i = 0; i < 2; i++) begin
         drive_and_step(8'hFF, 1'b1);
         got = {bus.code, bus.valid, bus.err};
         checks++;
         if (got !== 5'b000_0_0)
            $display("FAIL reset_cycle%0d: got %b expected %b", i, got, 5'b000_0_0);
         else
            passed++;
      end
   endtask

   task automatic test_onehot_walk();
      logic [4:0] got;
      logic [4:0] exp;
      for (int k = 0; k < 8; k++) begin
         drive_and_step(8'(1 << k), 1'b0);
         got = {bus.code, bus.valid, bus.err};
         exp = {3'(k), 1'b1, 1'b0};
         checks++;
         if (got !== exp)
            $display("FAIL onehot_A%0d: got %b expected %b", k, got, exp);
         else
            passed++;
      end
   endtask

   task automatic test_zero();
      logic [4:0] got;
      drive_and_step(8'h00, 1'b0);
      got = {bus.code, bus.valid, bus.err};
      checks++;
      if (got !== 5'b000_0_0)
         $display("FAIL all_zero: got %b expected %b", got, 5'b000_0_0);
      else
         passed++;
   endtask

   task automatic test_multi_hot();
      logic [7:0] vecs [4];
      logic [4:0] exps [4];
      logic [4:0] got;
      vecs[0] = 8'b0010_0110; exps[0] = 5'b101_1_1;
      vecs[1] = 8'b1000_0001; exps[1] = 5'b111_1_1;
      vecs[2] = 8'b0000_0011; exps[2] = 5'b001_1_1;
      vecs[3] = 8'b0101_1000; exps[3] = 5'b110_1_1;
      for (int i = 0; i < 4; i++) begin
         drive_and_step(vecs[i], 1'b0);
         got = {bus.code, bus.valid, bus.err};
         checks++;
         if (got !== exps[i])
            $display("FAIL multi_hot_%b: got %b expected %b", vecs[i], got, exps[i]);
         else
            passed++;
      end
   endtask

   task automatic test_reset_override();
      logic [4:0] got;
      drive_and_step(8'h40, 1'b0);
      drive_and_step(8'h08, 1'b1);
      got = {bus.code, bus.valid, bus.err};
      checks++;
      if (got !== 5'b000_0_0)
         $display("FAIL reset_override: got %b expected %b", got, 5'b000_0_0);
      else
         passed++;
      drive_and_step(8'h08, 1'b0);
      got = {bus.code, bus.valid, bus.err};
      checks++;
      if (got !== 5'b011_1_0)
         $display("FAIL after_reset_release: got %b expected %b", got, 5'b011_1_0);
      else
         passed++;
   endtask

   task automatic test_hold_between_edges();
      logic [4:0] got;
      drive_and_step(8'h20, 1'b0);
      got = {bus.code, bus.valid, bus.err};
      checks++;
      if (got !== 5'b101_1_0)
         $display("FAIL hold_initial: got %b expected %b", got, 5'b101_1_0);
      else
         passed++;
      #2;
      bus.req = 8'h01;
      #1;
      got = {bus.code, bus.valid, bus.err};
      checks++;
      if (got !== 5'b101_1_0)
         $display("FAIL hold_mid1: got %b expected %b", got, 5'b101_1_0);
      else
         passed++;
      #3;
      bus.req = 8'h81;
      #1;
      got = {bus.code, bus.valid, bus.err};
      checks++;
      if (got !== 5'b101_1_0)
         $display("FAIL hold_mid2: got %b expected %b", got, 5'b101_1_0);
      else
         passed++;
      @(posedge clk);
      #1;
      got = {bus.code, bus.valid, bus.err};
      checks++;
      if (got !== 5'b111_1_1)
         $display("FAIL hold_next_edge: got %b expected %b", got, 5'b111_1_1);
      else
         passed++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] vecs [5];
      logic [4:0] exps [5];
      logic [4:0] got;
      vecs[0] = 8'h40; exps[0] = 5'b110_1_0;
      vecs[1] = 8'h03; exps[1] = 5'b001_1_1;
      vecs[2] = 8'h00; exps[2] = 5'b000_0_0;
      vecs[3] = 8'hFF; exps[3] = 5'b111_1_1;
      vecs[4] = 8'h10; exps[4] = 5'b100_1_0;
      for (int i = 0; i < 5; i++) begin
         drive_and_step(vecs[i], 1'b0);
         got = {bus.code, bus.valid, bus.err};
         checks++;
         if (got !== exps[i])
            $display("FAIL back_to_back_%0d: got %b expected %b", i, got, exps[i]);
         else
            passed++;
      end
   endtask

   initial begin
      checks  = 0;
      passed  = 0;
      rst     = 1'b1;
      bus.req = 8'h00;
      test_reset();
      test_onehot_walk();
      test_zero();
      test_multi_hot();
      test_reset_override();
      test_hold_between_edges();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
